// File: rtl/alu_arb_pkg.sv
// Shared types, ALU function codes and helpers for the alu_arbiter slice.
// The function-code macros are guarded so an existing alucodes definition takes precedence.
`ifndef RADD
`define RADD 3'b001
`endif
`ifndef RSUB
`define RSUB 3'b010
`endif
`ifndef RMUL
`define RMUL 3'b011
`endif

package alu_arb_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  localparam int NREQ = 2;

  localparam logic [2:0] FUNC_RADD = `RADD;
  localparam logic [2:0] FUNC_RSUB = `RSUB;
  localparam logic [2:0] FUNC_RMUL = `RMUL;

  function automatic logic func_legal(input logic [2:0] func);
    return (func == `RADD) || (func == `RSUB) || (func == `RMUL);
  endfunction

endpackage

// File: rtl/alu.sv
// picoMIPS ALU: RADD/RSUB/RMUL on n-bit operands, flags {N,Z,C,V}.
// C is carry-out for RADD, borrow for RSUB, and "high half non-zero" for RMUL.
module alu #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [2:0]   func,
  output logic [n-1:0] result,
  output logic [3:0]   flags
);

  logic [n:0]     sum;
  logic [n:0]     diff;
  logic [2*n-1:0] prod;
  logic           c;
  logic           v;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign prod = {{n{1'b0}}, a} * {{n{1'b0}}, b};

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (func)
      `RADD: begin
        result = sum[n-1:0];
        c      = sum[n];
        v      = (a[n-1] == b[n-1]) && (sum[n-1] != a[n-1]);
      end
      `RSUB: begin
        result = diff[n-1:0];
        c      = diff[n];
        v      = (a[n-1] != b[n-1]) && (diff[n-1] != a[n-1]);
      end
      `RMUL: begin
        result = prod[n-1:0];
        c      = |prod[2*n-1:n];
      end
      default: ;
    endcase
  end

  assign flags = {result[n-1], (result == '0), c, v};

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, registered response.
// Optional ALU_ARB_BYPASS_EN lets HOLD accept a new request while the response is taken.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  input  logic [2:0]   req0_func,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  input  logic [2:0]   req1_func,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [n-1:0] rsp_result,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic         busy
);

  state_t          state, state_nxt;
  logic            rr_last;
  logic            grant_id;
  logic            arb_en;
  logic            accept;
  logic [NREQ-1:0] valid_vec;
  logic [NREQ-1:0] ready_vec;
  logic [n-1:0]    op_a, op_b;
  logic [2:0]      op_func;
  logic            op_id;
  logic            op_legal;
  logic [n-1:0]    alu_result;
  logic [3:0]      alu_flags;

  assign valid_vec = {req1_valid, req0_valid};
  assign grant_id  = (&valid_vec) ? ~rr_last : valid_vec[1];

`ifdef ALU_ARB_BYPASS_EN
  assign arb_en = (state == IDLE) || ((state == HOLD) && rsp_ready);
`else
  assign arb_en = (state == IDLE);
`endif

  always_comb begin
    ready_vec = '0;
    if (!reset && arb_en) ready_vec[grant_id] = valid_vec[grant_id];
  end

  assign accept     = |(ready_vec & valid_vec);
  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = HOLD;
      HOLD:    if (rsp_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_last    <= 1'b1;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) rr_last <= grant_id;
      if (state == EXEC) begin
        rsp_id     <= op_id;
        rsp_err    <= ~op_legal;
        rsp_result <= op_legal ? alu_result : '0;
        rsp_flags  <= op_legal ? alu_flags : 4'b0000;
      end
    end
  end

  // NOTE: operand registers carry no reset; they are only read in EXEC, always after a load.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a    <= grant_id ? req1_a : req0_a;
      op_b    <= grant_id ? req1_b : req0_b;
      op_func <= grant_id ? req1_func : req0_func;
      op_id   <= grant_id;
    end
  end

  assign op_legal  = func_legal(op_func);
  assign rsp_valid = (state == HOLD);
  assign busy      = (state != IDLE);

  alu #(.n(n)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .func   (op_func),
    .result (alu_result),
    .flags  (alu_flags)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

`ifdef ALU_ARB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_func, req1_func;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [7:0] rsp_result;
  logic [3:0] rsp_flags;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one op may be outstanding; its response is due two cycles after acceptance.
  bit         inflight = 1'b0;
  bit         last = 1'b1;
  int         cycle = 0;
  int         due = 0;
  int         acc_cycle = 0;
  bit         accepted_now = 1'b0;
  logic       exp_id = 1'b0;
  logic [7:0] exp_r = '0;
  logic [3:0] exp_f = '0;
  logic       exp_e = 1'b0;
  int         got_ids[$];
  int         rsp_cycles[$];

  alu_arbiter #(.n(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_func  (req0_func),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_func  (req1_func),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain-arithmetic ALU reference: unsigned/signed integer results and range tests.
  function automatic void ref_alu(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic [3:0] fl, output logic e);
    int ua, ub, sa, sb, full, sfull;
    bit c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    full = 0; c = 1'b0; v = 1'b0; e = 1'b0;
    if (f == FUNC_RADD) begin
      full = ua + ub; sfull = sa + sb;
      c = (full > 255); v = (sfull > 127) || (sfull < -128);
    end else if (f == FUNC_RSUB) begin
      full = ua - ub; sfull = sa - sb;
      c = (ua < ub); v = (sfull > 127) || (sfull < -128);
    end else if (f == FUNC_RMUL) begin
      full = ua * ub;
      c = (full > 255);
    end else begin
      e = 1'b1;
    end
    r  = e ? 8'h00 : full[7:0];
    fl = e ? 4'b0000 : {r[7], (r == 8'h00), c, v};
  endfunction

  task automatic tick(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [2:0] f0,
                      input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [2:0] f1,
                      input logic rr);
    logic g, e0, e1, ev, can, obs_id;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_func = f0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_func = f1;
    rsp_ready  = rr;
    #1;
    can = !inflight || (BYP && (cycle >= due) && rr);
    g   = (v0 && v1) ? ~last : v1;
    e0  = can && v0 && !g;
    e1  = can && v1 && g;
    ev  = inflight && (cycle >= due);
    check("req0_ready", req0_ready, e0);
    check("req1_ready", req1_ready, e1);
    check("rsp_valid", rsp_valid, ev);
    check("busy", busy, inflight);
    if (rsp_valid) rsp_cycles.push_back(cycle);
    obs_id = rsp_id;
    if (ev) begin
      check("rsp_id", rsp_id, exp_id);
      check("rsp_result", rsp_result, exp_r);
      check("rsp_flags", rsp_flags, exp_f);
      check("rsp_err", rsp_err, exp_e);
    end
    @(posedge clk);
    #1;
    cycle++;
    accepted_now = e0 || e1;
    if (ev && rr) begin
      inflight = 1'b0;
      got_ids.push_back(int'(obs_id));
    end
    if (e0 || e1) begin
      inflight  = 1'b1;
      acc_cycle = cycle - 1;
      due       = cycle + 1;
      last      = g;
      exp_id    = g;
      ref_alu(g ? f1 : f0, g ? a1 : a0, g ? b1 : b0, exp_r, exp_f, exp_e);
    end
  endtask

  task automatic idle(input logic rr);
    tick(1'b0, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 8'h00, 3'b000, rr);
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && inflight; k++) idle(1'b1);
  endtask

  task automatic run_one(input logic id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] f);
    accepted_now = 1'b0;
    for (int k = 0; k < 10 && !accepted_now; k++) begin
      if (id) tick(1'b0, 8'h00, 8'h00, 3'b000, 1'b1, a, b, f, 1'b1);
      else    tick(1'b1, a, b, f, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
    end
    drain();
  endtask

  initial begin
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_func = FUNC_RADD;
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_func = FUNC_RSUB;
    rsp_ready  = 1'b1;

    // Reset state, with both requesters valid to show ready is held low.
    #3;
    check("rst_req0_ready", req0_ready, 1'b0);
    check("rst_req1_ready", req1_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_result", rsp_result, 8'h00);
    check("rst_rsp_flags", rsp_flags, 4'h0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: add on requester 0, response two cycles after acceptance.
    rsp_cycles.delete();
    run_one(1'b0, 8'h04, 8'h03, FUNC_RADD);
    check("t1_latency", rsp_cycles[0] - acc_cycle, 2);
    check("t1_result", rsp_result, 8'h07);
    check("t1_flags", rsp_flags, 4'b0000);
    check("t1_id", rsp_id, 1'b0);

    // 2: subtract on requester 1, negative then zero result.
    run_one(1'b1, 8'h03, 8'h04, FUNC_RSUB);
    check("t2_result", rsp_result, 8'hFF);
    check("t2_n", rsp_flags[3], 1'b1);
    check("t2_z", rsp_flags[2], 1'b0);
    check("t2_id", rsp_id, 1'b1);
    run_one(1'b1, 8'h04, 8'h04, FUNC_RSUB);
    check("t2_zero_result", rsp_result, 8'h00);
    check("t2_zero_z", rsp_flags[2], 1'b1);

    // 3: both valid every cycle, grants must alternate starting with requester 0.
    got_ids.delete();
    for (int i = 0; i < 15; i++) tick(1'b1, 8'h04, 8'h03, FUNC_RMUL, 1'b1, 8'h05, 8'h05, FUNC_RMUL, 1'b1);
    drain();
    check("t3_count", got_ids.size() >= 4, 1'b1);
    foreach (got_ids[i]) check("t3_alternate", got_ids[i], i % 2);

    // 4: consumer stalls for five cycles while both requesters keep asking.
    accepted_now = 1'b0;
    for (int k = 0; k < 10 && !accepted_now; k++)
      tick(1'b1, 8'h7F, 8'h01, FUNC_RADD, 1'b0, 8'h00, 8'h00, 3'b000, 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, 8'h09, 8'h09, FUNC_RADD, 1'b1, 8'h0A, 8'h0A, FUNC_RSUB, 1'b0);
    check("t4_hold_result", rsp_result, 8'h80);
    check("t4_hold_flags", rsp_flags, 4'b1001);
    idle(1'b1);
    check("t4_idle_after_release", busy, 1'b0);

    // 5: illegal function code.
    run_one(1'b0, 8'h55, 8'h22, 3'b111);
    check("t5_err", rsp_err, 1'b1);
    check("t5_result", rsp_result, 8'h00);
    check("t5_flags", rsp_flags, 4'h0);

    // 6: reset while the accepted op is in EXEC; it must vanish and req0 must win next.
    tick(1'b1, 8'h01, 8'h02, FUNC_RADD, 1'b0, 8'h00, 8'h00, 3'b000, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_busy_in_reset", busy, 1'b0);
    check("t6_rsp_valid_in_reset", rsp_valid, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    inflight = 1'b0;
    last = 1'b1;
    for (int i = 0; i < 3; i++) idle(1'b1);
    tick(1'b1, 8'h02, 8'h02, FUNC_RADD, 1'b1, 8'h03, 8'h03, FUNC_RADD, 1'b1);
    drain();
    check("t6_first_grant_id", rsp_id, 1'b0);
    check("t6_first_result", rsp_result, 8'h04);

    // 7: continuous traffic, response spacing.
    rsp_cycles.delete();
    for (int i = 0; i < 24; i++)
      tick(1'b1, 8'($urandom), 8'($urandom), FUNC_RADD, 1'b1, 8'($urandom), 8'($urandom), FUNC_RMUL, 1'b1);
    drain();
    for (int i = 1; i < rsp_cycles.size(); i++)
      check("t7_spacing", rsp_cycles[i] - rsp_cycles[i-1], BYP ? 2 : 3);

    // Random traffic, including illegal codes and consumer back-pressure.
    for (int i = 0; i < 400; i++)
      tick(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) != 0));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
